// File: rtl/parking_pkg.sv
// Shared definitions for the parking gate controller: default timing
// parameters, FSM state encodings and a keypad slot qualifier.
package parking_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 4;
    localparam int GATE_TIMEOUT_DEF    = 50;

    typedef enum logic [1:0] {
        E_IDLE   = 2'd0,
        E_GRANT  = 2'd1,
        E_OPEN   = 2'd2,
        E_REFUSE = 2'd3
    } entry_state_t;

    typedef enum logic [1:0] {
        X_IDLE     = 2'd0,
        X_WAIT_KEY = 2'd1,
        X_ISSUE    = 2'd2,
        X_OPEN     = 2'd3
    } exit_state_t;

    // Slot 0 is not a real parking slot; keypad entries naming it are dropped.
    function automatic logic slot_valid(input logic [2:0] slot);
        return slot != 3'd0;
    endfunction

endpackage

// File: rtl/parking_gate_if.sv
// Lane sensors, exit keypad and downstream parking-system signals of the
// gate controller. The controller uses the slave side.
interface parking_gate_if;
    logic       entry_sensor;
    logic       exit_sensor;
    logic       key_valid;
    logic [2:0] key_slot;
    logic [7:0] key_code;
    logic       can_park;
    logic       car_arrival;
    logic       car_exit;
    logic [2:0] exit_from;
    logic [7:0] exit_code;
    logic       entry_open;
    logic       exit_open;
    logic       full_lamp;

    modport master (
        output entry_sensor, exit_sensor, key_valid, key_slot, key_code, can_park,
        input  car_arrival, car_exit, exit_from, exit_code, entry_open, exit_open, full_lamp
    );

    modport slave (
        input  entry_sensor, exit_sensor, key_valid, key_slot, key_code, can_park,
        output car_arrival, car_exit, exit_from, exit_code, entry_open, exit_open, full_lamp
    );
endinterface

// File: rtl/sensor_debounce.sv
// Car-present sensor debouncer. The debounced level follows the raw input
// only after DEBOUNCE_CYCLES consecutive cycles at the new value; o_rise
// pulses for one cycle right after the level goes high. The raw input is
// expected to be synchronous to clock already.
module sensor_debounce
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clock,
    input  logic g1_reset,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] C_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          r_level;
    logic          r_rise;

    // Count consecutive cycles the raw value disagrees with the level; flip on the last one.
    always_ff @(posedge clock or negedge g1_reset) begin
        if (!g1_reset) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            if (i_raw == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == C_LAST) begin
                r_cnt   <= '0;
                r_level <= i_raw;
                r_rise  <= i_raw;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking gate controller: one entry and one exit barrier, each driven by a
// debounced lane sensor and its own FSM. All outputs are registered.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// E_IDLE     | entry lane empty, waiting for a debounced car arrival
// E_GRANT    | slot free; car_arrival pulse (held back one cycle by car_exit)
// E_OPEN     | entry barrier open until the car leaves or the timeout expires
// E_REFUSE   | no slot free; full lamp on until the car leaves
// X_IDLE     | exit lane empty, waiting for a debounced car
// X_WAIT_KEY | car waiting at exit, waiting for a keypad entry with slot 1..7
// X_ISSUE    | one-cycle car_exit pulse carrying the latched slot and code
// X_OPEN     | exit barrier open until the car leaves or the timeout expires
module parking_gate_ctrl
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int GATE_TIMEOUT    = GATE_TIMEOUT_DEF
) (
    input logic           clock,
    input logic           g1_reset,
    parking_gate_if.slave bus
);

    localparam int TW = $clog2(GATE_TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(GATE_TIMEOUT - 1);
    localparam logic [TW-1:0] T_MAX  = TW'(GATE_TIMEOUT);

    entry_state_t  r_e_state;
    exit_state_t   r_x_state;
    logic [TW-1:0] r_e_cnt;
    logic [TW-1:0] r_x_cnt;
    logic          r_car_arrival;
    logic          r_entry_open;
    logic          r_full_lamp;
    logic          r_car_exit;
    logic [2:0]    r_exit_from;
    logic [7:0]    r_exit_code;
    logic          r_exit_open;

    logic w_e_level, w_e_rise, w_x_level, w_x_rise;
    logic w_key_ok, w_x_to_issue;

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_entry (
        .clock   (clock),
        .g1_reset(g1_reset),
        .i_raw   (bus.entry_sensor),
        .o_level (w_e_level),
        .o_rise  (w_e_rise)
    );

    sensor_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_exit (
        .clock   (clock),
        .g1_reset(g1_reset),
        .i_raw   (bus.exit_sensor),
        .o_level (w_x_level),
        .o_rise  (w_x_rise)
    );

    // The exit FSM enters X_ISSUE on the next edge; the arrival pulse yields to it.
    assign w_key_ok     = bus.key_valid && slot_valid(bus.key_slot);
    assign w_x_to_issue = (r_x_state == X_WAIT_KEY) && w_key_ok;

    // Entry FSM with registered barrier, lamp and arrival outputs.
    always_ff @(posedge clock or negedge g1_reset) begin
        if (!g1_reset) begin
            r_e_state     <= E_IDLE;
            r_e_cnt       <= '0;
            r_car_arrival <= 1'b0;
            r_entry_open  <= 1'b0;
            r_full_lamp   <= 1'b0;
        end else begin
            case (r_e_state)
                E_IDLE: begin
                    if (w_e_rise) begin
                        if (bus.can_park) begin
                            r_e_state     <= E_GRANT;
                            r_car_arrival <= !w_x_to_issue;
                        end else begin
                            r_e_state   <= E_REFUSE;
                            r_full_lamp <= 1'b1;
                        end
                    end
                end
                E_GRANT: begin
                    if (r_car_arrival) begin
                        r_car_arrival <= 1'b0;
                        r_entry_open  <= 1'b1;
                        r_e_cnt       <= '0;
                        r_e_state     <= E_OPEN;
                    end else begin
                        r_car_arrival <= !w_x_to_issue;
                    end
                end
                E_OPEN: begin
                    if (!w_e_level || (r_e_cnt >= T_LAST)) begin
                        r_entry_open <= 1'b0;
                        r_e_state    <= E_IDLE;
                    end else begin
                        r_e_cnt <= (r_e_cnt == T_MAX) ? r_e_cnt : r_e_cnt + 1'b1;
                    end
                end
                E_REFUSE: begin
                    if (!w_e_level) begin
                        r_full_lamp <= 1'b0;
                        r_e_state   <= E_IDLE;
                    end
                end
                default: r_e_state <= E_IDLE;
            endcase
        end
    end

    // Exit FSM with registered barrier and exit-pulse outputs; slot and code are latched into the outputs.
    always_ff @(posedge clock or negedge g1_reset) begin
        if (!g1_reset) begin
            r_x_state   <= X_IDLE;
            r_x_cnt     <= '0;
            r_car_exit  <= 1'b0;
            r_exit_from <= 3'd0;
            r_exit_code <= 8'd0;
            r_exit_open <= 1'b0;
        end else begin
            case (r_x_state)
                X_IDLE: begin
                    if (w_x_rise) begin
                        r_x_cnt   <= '0;
                        r_x_state <= X_WAIT_KEY;
                    end
                end
                X_WAIT_KEY: begin
                    if (w_key_ok) begin
                        r_car_exit  <= 1'b1;
                        r_exit_from <= bus.key_slot;
                        r_exit_code <= bus.key_code;
                        r_x_state   <= X_ISSUE;
                    end else if (r_x_cnt >= T_LAST) begin
                        r_x_state <= X_IDLE;
                    end else begin
                        r_x_cnt <= (r_x_cnt == T_MAX) ? r_x_cnt : r_x_cnt + 1'b1;
                    end
                end
                X_ISSUE: begin
                    r_car_exit  <= 1'b0;
                    r_exit_from <= 3'd0;
                    r_exit_code <= 8'd0;
                    r_exit_open <= 1'b1;
                    r_x_cnt     <= '0;
                    r_x_state   <= X_OPEN;
                end
                X_OPEN: begin
                    if (!w_x_level || (r_x_cnt >= T_LAST)) begin
                        r_exit_open <= 1'b0;
                        r_x_state   <= X_IDLE;
                    end else begin
                        r_x_cnt <= (r_x_cnt == T_MAX) ? r_x_cnt : r_x_cnt + 1'b1;
                    end
                end
                default: r_x_state <= X_IDLE;
            endcase
        end
    end

    assign bus.car_arrival = r_car_arrival;
    assign bus.entry_open  = r_entry_open;
    assign bus.full_lamp   = r_full_lamp;
    assign bus.car_exit    = r_car_exit;
    assign bus.exit_from   = r_exit_from;
    assign bus.exit_code   = r_exit_code;
    assign bus.exit_open   = r_exit_open;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Bench for parking_gate_ctrl: table of entry scenarios, hand-written exit,
// coincidence and reset sequences, then randomized lane transactions checked
// against an event-level model (pulse counts and payloads).
module tb_parking_gate_ctrl;

    logic clock    = 1'b0;
    logic g1_reset = 1'b0;

    parking_gate_if bus();

    parking_gate_ctrl #(.DEBOUNCE_CYCLES(4), .GATE_TIMEOUT(50)) dut (
        .clock   (clock),
        .g1_reset(g1_reset),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int n_arr, n_exit, n_eopen, n_xopen;
    int arr_cyc, exit_cyc, first_eopen, last_eopen;
    bit lamp_seen;
    logic [10:0] q_exit[$];
    int c_rise, c_fall;

    int k_slot[4];
    int k_code[4];
    int k_gap[4];

    typedef struct {
        int cp;
        int hi;
        int arr;
        int lamp;
        int open_cycles;
    } ent_vec_t;

    ent_vec_t tv[6];

    task automatic chk(input string nm, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", nm, act, req);
        end
    endtask

    function automatic int outs();
        return int'({bus.car_arrival, bus.car_exit, bus.exit_from, bus.exit_code,
                     bus.entry_open, bus.exit_open, bus.full_lamp});
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (bus.car_arrival) begin
            n_arr++;
            arr_cyc = cyc;
        end
        if (bus.car_exit) begin
            n_exit++;
            exit_cyc = cyc;
            q_exit.push_back({bus.exit_from, bus.exit_code});
        end else begin
            chk("exit_payload_idle_zero", int'({bus.exit_from, bus.exit_code}), 0);
        end
        if (bus.entry_open) begin
            n_eopen++;
            last_eopen = cyc;
            if (first_eopen < 0) first_eopen = cyc;
        end
        if (bus.full_lamp) lamp_seen = 1'b1;
        if (bus.exit_open) n_xopen++;
    end

    task automatic ncyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic clr();
        n_arr = 0; n_exit = 0; n_eopen = 0; n_xopen = 0;
        arr_cyc = -1; exit_cyc = -1; first_eopen = -1; last_eopen = -1;
        lamp_seen = 1'b0;
        q_exit.delete();
    endtask

    task automatic send_key(input int s, input int c);
        bus.key_valid = 1'b1;
        bus.key_slot  = s[2:0];
        bus.key_code  = c[7:0];
        ncyc(1);
        bus.key_valid = 1'b0;
        bus.key_slot  = 3'd0;
        bus.key_code  = 8'd0;
    endtask

    task automatic run_entry(input int cp, input int g, input int gp, input int h);
        clr();
        bus.can_park = cp[0];
        if (g > 0) begin
            bus.entry_sensor = 1'b1;
            ncyc(g);
            bus.entry_sensor = 1'b0;
            ncyc(gp);
        end
        bus.entry_sensor = 1'b1;
        c_rise = cyc;
        ncyc(h);
        bus.entry_sensor = 1'b0;
        c_fall = cyc;
        ncyc(25);
    endtask

    task automatic run_exit(input int nk);
        clr();
        bus.exit_sensor = 1'b1;
        ncyc(8);
        for (int i = 0; i < nk; i++) begin
            send_key(k_slot[i], k_code[i]);
            ncyc(k_gap[i]);
        end
        ncyc(4);
        bus.exit_sensor = 1'b0;
        ncyc(20);
    endtask

    // Model: the first keypad entry naming a real slot is reported exactly once.
    task automatic check_exit(input string nm, input int nk);
        int first;
        first = -1;
        for (int i = 0; i < nk; i++)
            if (first < 0 && k_slot[i] != 0) first = i;
        chk({nm, "_exit_count"}, n_exit, (first >= 0) ? 1 : 0);
        chk({nm, "_exit_open_seen"}, int'(n_xopen > 0), int'(first >= 0));
        if (first >= 0)
            chk({nm, "_exit_payload"}, (q_exit.size() > 0) ? int'(q_exit[0]) : -1,
                (k_slot[first] << 8) | k_code[first]);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cp, g, gp, h, nk, ev;

        tv[0] = '{cp: 1, hi: 10, arr: 1, lamp: 0, open_cycles: 9};
        tv[1] = '{cp: 0, hi: 10, arr: 0, lamp: 1, open_cycles: 0};
        tv[2] = '{cp: 1, hi: 2,  arr: 0, lamp: 0, open_cycles: 0};
        tv[3] = '{cp: 1, hi: 3,  arr: 0, lamp: 0, open_cycles: 0};
        tv[4] = '{cp: 1, hi: 4,  arr: 1, lamp: 0, open_cycles: 3};
        tv[5] = '{cp: 1, hi: 80, arr: 1, lamp: 0, open_cycles: 50};

        bus.entry_sensor = 1'b0;
        bus.exit_sensor  = 1'b0;
        bus.key_valid    = 1'b0;
        bus.key_slot     = 3'd0;
        bus.key_code     = 8'd0;
        bus.can_park     = 1'b0;
        clr();

        ncyc(3);
        chk("reset_outputs", outs(), 0);
        g1_reset = 1'b1;
        ncyc(3);

        // Entry scenarios from the table.
        for (int i = 0; i < 6; i++) begin
            run_entry(tv[i].cp, 0, 0, tv[i].hi);
            chk($sformatf("tv%0d_arrivals", i), n_arr, tv[i].arr);
            chk($sformatf("tv%0d_full_lamp_seen", i), int'(lamp_seen), tv[i].lamp);
            chk($sformatf("tv%0d_entry_open_cycles", i), n_eopen, tv[i].open_cycles);
            chk($sformatf("tv%0d_lamp_off_after", i), int'(bus.full_lamp), 0);
            if (tv[i].arr == 1)
                chk($sformatf("tv%0d_arrival_delay_4to5", i),
                    int'((arr_cyc - c_rise) >= 4 && (arr_cyc - c_rise) <= 5), 1);
            if (tv[i].arr == 1 && tv[i].hi < 50)
                chk($sformatf("tv%0d_close_delay_3to5", i),
                    int'((last_eopen - c_fall) >= 3 && (last_eopen - c_fall) <= 5), 1);
        end

        // Key before the exit car is debounced is ignored; slot 7 / code 54 is issued once.
        clr();
        bus.exit_sensor = 1'b1;
        ncyc(1);
        send_key(3, 99);
        ncyc(6);
        send_key(7, 54);
        ncyc(6);
        bus.exit_sensor = 1'b0;
        ncyc(20);
        chk("exit7_count", n_exit, 1);
        chk("exit7_payload", (q_exit.size() > 0) ? int'(q_exit[0]) : -1, (7 << 8) | 54);
        chk("exit7_open_seen", int'(n_xopen > 0), 1);
        chk("exit7_open_closed", int'(bus.exit_open), 0);

        // Slot 0 ignored, key wait times out, later key lands in X_IDLE and is ignored.
        clr();
        bus.exit_sensor = 1'b1;
        ncyc(8);
        send_key(0, 90);
        ncyc(60);
        send_key(5, 17);
        ncyc(10);
        chk("timeout_no_exit", n_exit, 0);
        chk("timeout_no_open", n_xopen, 0);
        bus.exit_sensor = 1'b0;
        ncyc(20);

        // Arrival grant and exit issue in the same cycle.
        clr();
        bus.exit_sensor = 1'b1;
        ncyc(8);
        bus.can_park = 1'b1;
        bus.entry_sensor = 1'b1;
        c_rise = cyc;
        ncyc(4);
        send_key(2, 33);
        ncyc(10);
        bus.entry_sensor = 1'b0;
        bus.exit_sensor  = 1'b0;
        ncyc(25);
        chk("coinc_exit_count", n_exit, 1);
        chk("coinc_arrival_count", n_arr, 1);
        chk("coinc_exit_cycle", exit_cyc - c_rise, 5);
        chk("coinc_arrival_after_exit", arr_cyc - exit_cyc, 1);
        chk("coinc_open_after_arrival", first_eopen - arr_cyc, 1);

        // Reset pulsed while the entry barrier is open.
        clr();
        bus.can_park = 1'b1;
        bus.entry_sensor = 1'b1;
        ncyc(12);
        chk("pre_reset_entry_open", int'(bus.entry_open), 1);
        #2;
        g1_reset = 1'b0;
        #1;
        chk("reset_mid_op_outputs", outs(), 0);
        @(negedge clock);
        bus.entry_sensor = 1'b0;
        ncyc(3);
        chk("reset_held_outputs", outs(), 0);
        g1_reset = 1'b1;
        clr();
        ncyc(20);
        chk("post_reset_no_arrival", n_arr, 0);
        chk("post_reset_no_open", n_eopen, 0);

        // Randomized lane transactions.
        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                cp = int'($urandom_range(0, 1));
                g  = int'($urandom_range(0, 3));
                gp = int'($urandom_range(1, 3));
                h  = int'($urandom_range(1, 12));
                run_entry(cp, g, gp, h);
                ev = (h >= 4) ? 1 : 0;
                chk($sformatf("rnd%0d_arrivals", it), n_arr, ev & cp);
                chk($sformatf("rnd%0d_lamp_seen", it), int'(lamp_seen), ev & (1 - cp));
                chk($sformatf("rnd%0d_open_seen", it), int'(n_eopen > 0), ev & cp);
            end else begin
                nk = int'($urandom_range(1, 4));
                for (int i = 0; i < 4; i++) begin
                    k_slot[i] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 7));
                    k_code[i] = int'($urandom_range(0, 255));
                    k_gap[i]  = int'($urandom_range(1, 3));
                end
                run_exit(nk);
                check_exit($sformatf("rnd%0d", it), nk);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parking_gate_ctrl.md
PARKING_GATE_CTRL -- requirements
Module: parking_gate_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, SHALL set the consecutive stable cycles needed to change a debounced sensor level.
REQ-002 Parameter GATE_TIMEOUT, default 50, SHALL set the maximum cycles a barrier stays open, or an exit waits for a key entry.
REQ-003 Port clock  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 Port g1_reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port entry_sensor  input  1  SHALL be the raw car-present sensor at the entry lane.
REQ-006 Port exit_sensor  input  1  SHALL be the raw car-present sensor at the exit lane.
REQ-007 Port key_valid  input  1  SHALL be a one-cycle strobe qualifying key_slot and key_code.
REQ-008 Port key_slot  input  3  SHALL be the slot number entered at the exit keypad; valid range 1..7.
REQ-009 Port key_code  input  8  SHALL be the exit code entered at the exit keypad.
REQ-010 Port can_park  input  1  SHALL be the downstream parking-system flag meaning at least one slot is free.
REQ-011 Port car_arrival  output  1  SHALL be a one-cycle arrival pulse to the downstream parking system.
REQ-012 Port car_exit  output  1  SHALL be a one-cycle exit pulse to the downstream parking system.
REQ-013 Port exit_from  output  3  SHALL carry the slot for car_exit; 0 when car_exit is low.
REQ-014 Port exit_code  output  8  SHALL carry the code for car_exit; 0 when car_exit is low.
REQ-015 Ports entry_open and exit_open  output  1 each  SHALL be the barrier-open commands.
REQ-016 Port full_lamp  output  1  SHALL mean an entry request was refused because no slot was free.

Function
REQ-017 Each raw sensor SHALL be debounced; the debounced level changes only after DEBOUNCE_CYCLES consecutive cycles at the new raw value.
REQ-018 The entry FSM SHALL have the states E_IDLE, E_GRANT, E_OPEN and E_REFUSE.
REQ-019 In E_IDLE, a debounced entry rising edge SHALL move to E_GRANT if can_park=1, and to E_REFUSE otherwise.
REQ-020 E_GRANT SHALL assert car_arrival for exactly one cycle, then move to E_OPEN.
REQ-021 E_OPEN SHALL hold entry_open=1 until the debounced entry sensor falls or GATE_TIMEOUT cycles elapse, then return to E_IDLE.
REQ-022 E_REFUSE SHALL hold full_lamp=1 until the debounced entry sensor falls, then return to E_IDLE; no arrival pulse is issued.
REQ-023 The exit FSM SHALL have the states X_IDLE, X_WAIT_KEY, X_ISSUE and X_OPEN.
REQ-024 In X_IDLE, a debounced exit rising edge SHALL move to X_WAIT_KEY and clear the timeout counter.
REQ-025 In X_WAIT_KEY, key_valid with key_slot in 1..7 SHALL latch slot and code and move to X_ISSUE.
REQ-026 In X_WAIT_KEY, key_valid with key_slot=0 SHALL be ignored.
REQ-027 In X_WAIT_KEY, reaching GATE_TIMEOUT with no valid key SHALL return to X_IDLE with no exit pulse.
REQ-028 X_ISSUE SHALL drive car_exit=1 with the latched exit_from/exit_code for exactly one cycle, then move to X_OPEN.
REQ-029 X_OPEN SHALL behave as E_OPEN, using exit_open and the exit sensor.
REQ-030 When E_GRANT and X_ISSUE coincide, the exit pulse SHALL win; the arrival pulse is issued in the next cycle, and E_OPEN is entered one cycle later.
REQ-031 The timeout counters SHALL saturate at GATE_TIMEOUT and never wrap.
REQ-032 A key_valid outside X_WAIT_KEY SHALL be ignored.

Reset
REQ-033 While g1_reset=0, both FSMs SHALL be in their IDLE state, all counters and debounced levels SHALL be 0, and every output SHALL be 0.
REQ-034 Reset asserted mid-operation SHALL immediately close both barriers and drop any pending pulse, without replaying it after release.

Structure
REQ-035 The state encodings and the default values of DEBOUNCE_CYCLES and GATE_TIMEOUT SHALL live in the shared package parking_pkg.
REQ-036 The debouncer SHALL be the sub-module sensor_debounce, instantiated once per lane.

Verification
REQ-037 can_park=1, entry_sensor high for 10 cycles then low -> car_arrival pulses once, 4–5 cycles after the rise; entry_open is high until about 4 cycles after the fall.
REQ-038 can_park=0, entry_sensor high -> full_lamp=1, car_arrival never asserts, entry_open stays 0.
REQ-039 exit_sensor high, then key_valid with slot=7, code=54 -> one cycle of car_exit=1, exit_from=7, exit_code=54; all three are 0 before and after.
REQ-040 exit_sensor high, key_slot=0, and no further key for 50 cycles -> no car_exit, FSM returns to X_IDLE, exit_open stays 0.
REQ-041 Arrival grant and exit issue forced into the same cycle -> car_exit in cycle N, car_arrival in cycle N+1.
REQ-042 A 2-cycle entry_sensor glitch -> no state change; g1_reset pulsed low during E_OPEN -> all outputs 0 immediately.
